ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 37 +++
 rtl/ex_stage_alu.sv | 48 ++++
 rtl/ex_stage.sv | 152 +++++++++++++++
 tb/tb_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared CPU types: ALU operations, branch conditions and
// execute-stage occupancy states.
package rvcpu;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU
    } br_cond_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_t;

    // x0 is hardwired, so writing it is never useful.
    function automatic logic writes_rd(logic is_branch, logic [4:0] rd);
        return !is_branch && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU; invert_b turns ADD into SUB and
// complements b for the logic ops.
module alu
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  alu_op_t          op_i,
    input  logic             invert_b_i,
    output logic [Width-1:0] res_o,
    output logic             zero_o,
    output logic             carry_o
);

    localparam int ShW = $clog2(Width);

    logic [Width-1:0] b_eff;
    logic [Width:0]   sum;
    logic [ShW-1:0]   shamt;

    assign b_eff = invert_b_i ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff}
                 + {{Width{1'b0}}, invert_b_i};
    assign shamt = b_i[ShW-1:0];

    always_comb begin
        res_o = '0;
        unique case (op_i)
            ALU_ADD:  res_o = sum[Width-1:0];
            ALU_AND:  res_o = a_i & b_eff;
            ALU_OR:   res_o = a_i | b_eff;
            ALU_XOR:  res_o = a_i ^ b_eff;
            ALU_SLL:  res_o = a_i << shamt;
            ALU_SRL:  res_o = a_i >> shamt;
            ALU_SRA:  res_o = $signed(a_i) >>> shamt;
            ALU_SLT:  res_o = {{(Width-1){1'b0}},
                               $signed(a_i) < $signed(b_i)};
            ALU_SLTU: res_o = {{(Width-1){1'b0}}, a_i < b_i};
            default:  res_o = '0;
        endcase
    end

    assign zero_o  = (res_o == '0);
    assign carry_o = sum[Width];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU + branch resolve into a two-entry
// skid buffer with a registered in_ready.
module ex_stage
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          in_op,
    input  logic [Width-1:0] in_a,
    input  logic [Width-1:0] in_b,
    input  logic             in_invert_b,
    input  logic             in_is_branch,
    input  br_cond_t         in_cond,
    input  logic [Width-1:0] in_pc,
    input  logic [Width-1:0] in_imm,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_res,
    output logic [Width-1:0] out_target,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_taken
);

    occ_t             state_q;
    logic             out_valid_q, in_ready_q;
    logic [Width-1:0] res_q, tgt_q, s_res_q, s_tgt_q;
    logic [4:0]       rd_q, s_rd_q;
    logic             we_q, taken_q, s_we_q, s_taken_q;

    logic [Width-1:0] res_d, tgt_d;
    logic             we_d, taken_d, cond_hit;
    logic             accept, retire;
    logic [1:0]       unused_flags;

    alu #(.Width(Width)) u_alu (
        .a_i        (in_a),
        .b_i        (in_b),
        .op_i       (in_op),
        .invert_b_i (in_invert_b),
        .res_o      (res_d),
        .zero_o     (unused_flags[0]),
        .carry_o    (unused_flags[1])
    );

    always_comb begin
        cond_hit = 1'b0;
        unique case (in_cond)
            BR_EQ:   cond_hit = (in_a == in_b);
            BR_NE:   cond_hit = (in_a != in_b);
            BR_LT:   cond_hit = $signed(in_a) < $signed(in_b);
            BR_GE:   cond_hit = $signed(in_a) >= $signed(in_b);
            BR_LTU:  cond_hit = in_a < in_b;
            BR_GEU:  cond_hit = in_a >= in_b;
            default: cond_hit = 1'b0;
        endcase
    end

    assign taken_d = in_is_branch && cond_hit;
    assign tgt_d   = in_pc + in_imm;
    assign we_d    = writes_rd(in_is_branch, in_rd);
    assign accept  = in_valid && in_ready_q;
    assign retire  = out_valid_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            res_q       <= '0;
            tgt_q       <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            taken_q     <= 1'b0;
            s_res_q     <= '0;
            s_tgt_q     <= '0;
            s_rd_q      <= '0;
            s_we_q      <= 1'b0;
            s_taken_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        res_q       <= res_d;
                        tgt_q       <= tgt_d;
                        rd_q        <= in_rd;
                        we_q        <= we_d;
                        taken_q     <= taken_d;
                        state_q     <= OCC_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    // Main is held while stalled; new work parks in skid.
                    if (accept && !retire) begin
                        s_res_q    <= res_d;
                        s_tgt_q    <= tgt_d;
                        s_rd_q     <= in_rd;
                        s_we_q     <= we_d;
                        s_taken_q  <= taken_d;
                        state_q    <= OCC_TWO;
                        in_ready_q <= 1'b0;
                    end else if (accept) begin
                        res_q   <= res_d;
                        tgt_q   <= tgt_d;
                        rd_q    <= in_rd;
                        we_q    <= we_d;
                        taken_q <= taken_d;
                    end else if (retire) begin
                        state_q     <= OCC_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                OCC_TWO: begin
                    if (retire) begin
                        res_q      <= s_res_q;
                        tgt_q      <= s_tgt_q;
                        rd_q       <= s_rd_q;
                        we_q       <= s_we_q;
                        taken_q    <= s_taken_q;
                        state_q    <= OCC_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= OCC_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_res    = res_q;
    assign out_target = tgt_q;
    assign out_rd     = rd_q;
    assign out_we     = we_q;
    assign out_taken  = taken_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_ex_stage;
    import rvcpu::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alu_op_t     in_op = ALU_ADD;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_invert_b = 1'b0;
    logic        in_is_branch = 1'b0;
    br_cond_t    in_cond = BR_EQ;
    logic [31:0] in_pc = '0, in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res, out_target;
    logic [4:0]  out_rd;
    logic        out_we, out_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
    } exp_t;

    exp_t q[$];

    ex_stage #(.Width(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_invert_b  (in_invert_b),
        .in_is_branch (in_is_branch),
        .in_cond      (in_cond),
        .in_pc        (in_pc),
        .in_imm       (in_imm),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_target   (out_target),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .out_taken    (out_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_op();
        exp_t e;
        logic [31:0] bb;
        logic c;
        bb = in_invert_b ? ~in_b : in_b;
        case (in_op)
            ALU_ADD:  e.res = in_invert_b ? in_a - in_b : in_a + in_b;
            ALU_AND:  e.res = in_a & bb;
            ALU_OR:   e.res = in_a | bb;
            ALU_XOR:  e.res = in_a ^ bb;
            ALU_SLL:  e.res = in_a << in_b[4:0];
            ALU_SRL:  e.res = in_a >> in_b[4:0];
            ALU_SRA:  e.res = $signed(in_a) >>> in_b[4:0];
            ALU_SLT:  e.res = ($signed(in_a) < $signed(in_b)) ? 1 : 0;
            ALU_SLTU: e.res = (in_a < in_b) ? 1 : 0;
            default:  e.res = '0;
        endcase
        case (in_cond)
            BR_EQ:   c = in_a == in_b;
            BR_NE:   c = in_a != in_b;
            BR_LT:   c = $signed(in_a) < $signed(in_b);
            BR_GE:   c = $signed(in_a) >= $signed(in_b);
            BR_LTU:  c = in_a < in_b;
            BR_GEU:  c = in_a >= in_b;
            default: c = 1'b0;
        endcase
        e.taken = in_is_branch && c;
        e.tgt   = in_pc + in_imm;
        e.rd    = in_rd;
        e.we    = !in_is_branch && in_rd != 0;
        return e;
    endfunction

    // Reference model: a FIFO of at most two results.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit acc, ret;
            acc = in_valid && q.size() < 2;
            ret = q.size() > 0 && out_ready;
            if (ret) void'(q.pop_front());
            if (acc) q.push_back(model_op());
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_ready", 32'(in_ready), 1);
            chk("rst_res", out_res, 0);
            chk("rst_tgt", out_target, 0);
            chk("rst_misc", {27'(out_rd), 3'b0, out_we, out_taken}, 0);
        end else begin
            chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("m_res", out_res, q[0].res);
                chk("m_tgt", out_target, q[0].tgt);
                chk("m_rd", 32'(out_rd), 32'(q[0].rd));
                chk("m_we", 32'(out_we), 32'(q[0].we));
                chk("m_taken", 32'(out_taken), 32'(q[0].taken));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(alu_op_t op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] rd);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_rd = rd;
        in_invert_b = 1'b0;
        in_is_branch = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;

        // add 5+7 -> 12 one cycle later
        out_ready = 1'b1;
        offer(ALU_ADD, 5, 7, 3);
        cyc();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 1);
        chk("add_res", out_res, 12);
        chk("add_we", 32'(out_we), 1);
        chk("add_ready", 32'(in_ready), 1);
        cyc();

        // stalled back-to-back ops
        out_ready = 1'b0;
        offer(ALU_ADD, 1, 0, 1);
        cyc();
        chk("bb_ready1", 32'(in_ready), 1);
        offer(ALU_ADD, 2, 0, 2);
        cyc();
        chk("bb_ready2", 32'(in_ready), 0);
        offer(ALU_ADD, 3, 0, 3);
        cyc();
        in_valid = 1'b0;
        chk("bb_hold", out_res, 1);
        out_ready = 1'b1;
        cyc();
        chk("bb_second", out_res, 2);
        chk("bb_rd", 32'(out_rd), 2);
        cyc();
        chk("bb_empty", 32'(out_valid), 0);

        // signed vs unsigned compare
        offer(ALU_ADD, 32'hFFFF_FFFF, 1, 5);
        in_is_branch = 1'b1;
        in_cond = BR_LT;
        cyc();
        chk("br_lt", 32'(out_taken), 1);
        chk("br_we", 32'(out_we), 0);
        in_cond = BR_LTU;
        cyc();
        chk("br_ltu", 32'(out_taken), 0);

        // target wraps
        in_pc = 32'hFFFF_FFF0;
        in_imm = 32'h20;
        cyc();
        chk("tgt_wrap", out_target, 32'h10);
        in_valid = 1'b0;
        cyc();

        // flush while full
        out_ready = 1'b0;
        offer(ALU_XOR, 6, 3, 4);
        cyc();
        cyc();
        chk("fl_full", 32'(in_ready), 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_ready", 32'(in_ready), 1);
        cyc();
        chk("fl_lost", 32'(out_valid), 0);

        // rd=0 never writes
        out_ready = 1'b1;
        offer(ALU_ADD, 9, 9, 0);
        cyc();
        chk("rd0_we", 32'(out_we), 0);
        chk("rd0_res", out_res, 18);

        // async reset mid-stall
        out_ready = 1'b0;
        offer(ALU_OR, 32'hF0, 32'h0F, 7);
        cyc();
        in_valid = 1'b0;
        chk("ar_pre", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_ready", 32'(in_ready), 1);
        chk("ar_res", out_res, 0);
        cyc();
        #2 rst = 1'b0;
        offer(ALU_SUB_LIKE(), 10, 4, 8);
        in_invert_b = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("ar_accept", 32'(out_valid), 1);
        chk("ar_sub", out_res, 6);
        out_ready = 1'b1;
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 40) == 0;
            in_op = alu_op_t'($urandom_range(0, 8));
            in_cond = br_cond_t'($urandom_range(0, 5));
            in_a = ($urandom % 2) ? $urandom : 32'($urandom % 8);
            in_b = ($urandom % 4) == 0 ? in_a : $urandom;
            if ($urandom % 3 == 0) in_b = 32'($urandom % 40);
            in_invert_b = ($urandom % 3) == 0;
            in_is_branch = ($urandom % 3) == 0;
            in_pc = $urandom;
            in_imm = $urandom;
            in_rd = ($urandom % 5) == 0 ? 5'd0 : 5'($urandom);
            if ($urandom % 300 == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            cyc();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    function automatic alu_op_t ALU_SUB_LIKE();
        return ALU_ADD;
    endfunction

endmodule
